uart_apb_master: RTL
====================

UART_APB_MASTER -- requirements
Module: uart_apb_master

Interface
REQ-001 Parameter APB_ADDR_WIDTH, default 32, APB address width.
REQ-002 Parameter APB_DATA_WIDTH, default 32, APB data width (multiple of 8).
REQ-003 Parameter TIMEOUT_CYCLES, default 16, maximum ACCESS-phase cycles before abort (range 1..255).
REQ-004 apb_clk_in  input  1  single clock; all logic on rising edge.
REQ-005 apb_rstn_in  input  1  reset, asynchronous, active-low.
REQ-006 cmd_valid_in  input  1  command request.
REQ-007 cmd_ready_out  output  1  block accepts a command this cycle.
REQ-008 cmd_addr_in  input  APB_ADDR_WIDTH  target address.
REQ-009 cmd_write_in  input  1  1=write, 0=read.
REQ-010 cmd_wdata_in  input  APB_DATA_WIDTH  write data.
REQ-011 cmd_strb_in  input  APB_DATA_WIDTH/8  write byte strobes.
REQ-012 rsp_valid_out  output  1  response available.
REQ-013 rsp_ready_in  input  1  response consumer ready.
REQ-014 rsp_rdata_out  output  APB_DATA_WIDTH  read data (0 for writes).
REQ-015 rsp_err_out  output  1  slave error or timeout.
REQ-016 rsp_timeout_out  output  1  transfer aborted by timeout.
REQ-017 apb_addr_out, apb_wdata_out, apb_strb_out, apb_write_out, apb_psel_out, apb_penable_out  outputs  APB request, all registered.
REQ-018 apb_rdata_in  input  APB_DATA_WIDTH; apb_ready_in  input  1; apb_slverr_in  input  1  APB response.

Function
REQ-019 FSM states SHALL be IDLE, SETUP, ACCESS, RESP; all outputs registered.
REQ-020 IDLE: cmd_ready_out=1; cmd_valid_in&cmd_ready_out SHALL capture addr/write/wdata/strb, drop cmd_ready_out, go SETUP next cycle.
REQ-021 SETUP (one cycle): apb_psel_out=1, apb_penable_out=0; go ACCESS unconditionally.
REQ-022 ACCESS: apb_psel_out=1, apb_penable_out=1; remain until apb_ready_in=1 sampled.
REQ-023 apb_addr/wdata/strb/write SHALL be stable from SETUP through final ACCESS cycle.
REQ-024 apb_strb_out SHALL be 0 for reads; apb_wdata_out SHALL be 0 for reads.
REQ-025 On apb_ready_in=1 in ACCESS: capture apb_rdata_in (reads; writes capture 0) and apb_slverr_in into rsp_rdata_out/rsp_err_out; deassert psel/penable next cycle; go RESP.
REQ-026 Minimum latency, zero-wait slave: acceptance cycle N, SETUP N+1, ACCESS N+2, rsp_valid_out=1 at N+3.
REQ-027 RESP: rsp_valid_out=1, response fields held stable until rsp_valid_out&rsp_ready_in; then IDLE with cmd_ready_out=1 next cycle.
REQ-028 rsp_ready_in already 1 on RESP entry SHALL complete RESP in one cycle (back-to-back command acceptance at N+4).
REQ-029 cmd_valid_in outside IDLE SHALL be ignored; cmd_* inputs sampled only at acceptance.
REQ-030 apb_ready_in/apb_slverr_in outside ACCESS SHALL be ignored.

Reset
REQ-031 Asserting apb_rstn_in SHALL immediately force state IDLE and all outputs 0 (including cmd_ready_out, apb_psel_out, apb_penable_out, rsp_valid_out), regardless of in-flight transfer.
REQ-032 cmd_ready_out SHALL rise on the first rising edge after reset release; aborted transfers produce no response.

Configuration
REQ-033 Macro APB_MASTER_TIMEOUT_EN defined: ACCESS-cycle counter (8-bit, cleared on SETUP) increments each ACCESS cycle without apb_ready_in; when count reaches TIMEOUT_CYCLES with apb_ready_in=0, deassert psel/penable next cycle, go RESP with rsp_err_out=1, rsp_timeout_out=1, rsp_rdata_out=0.
REQ-034 apb_ready_in=1 on the same cycle the limit is reached SHALL win (normal completion, rsp_timeout_out=0).
REQ-035 Macro undefined: no counter, ACCESS waits indefinitely, rsp_timeout_out tied 0, TIMEOUT_CYCLES unused; port list identical.

Verification
REQ-036 Write addr=0xA030_0004, wdata=0x0000_0F00, strb=0xF, zero-wait slave -> SETUP at N+1, ACCESS at N+2, rsp_valid at N+3, rsp_err=0, rsp_rdata=0.
REQ-037 Read addr=0xA030_0008, slave waits 3 cycles then returns 0x0000_C01B -> ACCESS lasts 4 cycles, addr stable, apb_strb_out=0, rsp_rdata=0x0000_C01B.
REQ-038 Read with apb_slverr_in=1 at ready -> rsp_err=1, rsp_timeout=0; rsp_ready_in held 0 for 5 cycles -> rsp_valid and fields stable all 5 cycles.
REQ-039 APB_MASTER_TIMEOUT_EN, TIMEOUT_CYCLES=16, slave never ready -> psel drops after 16 ACCESS cycles, rsp_err=1, rsp_timeout=1; ready on cycle 16 -> normal completion.
REQ-040 Reset asserted during ACCESS -> psel/penable 0 same instant, no rsp_valid; cmd_ready_out=1 first edge after release, next command completes normally.
REQ-041 Two commands back-to-back with rsp_ready_in=1 constant -> second accepted at N+4, second SETUP at N+5.

Source files
------------

// File: rtl/uart_apb_master.sv
// uart_apb_master
//   Command/response front end that turns one accepted command into one APB
//   transfer (SETUP, then ACCESS until the slave is ready) and returns a single
//   response. Every output comes straight from a flop.
//
//   Optional feature: define APB_MASTER_TIMEOUT_EN to abort an ACCESS phase
//   that lasts TIMEOUT_CYCLES cycles without apb_ready_in. The abort returns
//   rsp_err_out=1 and rsp_timeout_out=1. Without the macro the ACCESS phase
//   waits indefinitely and rsp_timeout_out is tied low.
//
//   Ports
//     apb_clk_in, apb_rstn_in        clock, async active-low reset
//     cmd_valid_in / cmd_ready_out   command handshake
//     cmd_addr_in, cmd_write_in,
//     cmd_wdata_in, cmd_strb_in      command payload, sampled only at acceptance
//     rsp_valid_out / rsp_ready_in   response handshake
//     rsp_rdata_out, rsp_err_out,
//     rsp_timeout_out                response payload
//     apb_*_out                      APB request
//     apb_rdata_in, apb_ready_in,
//     apb_slverr_in                  APB response, looked at only in ACCESS
//     dbg_state_out                  current FSM state (IDLE=0 SETUP=1 ACCESS=2 RESP=3)
//
//   Handshake rule (both cmd and rsp): a transfer happens on a rising edge
//   where valid and ready are both 1. A producer holding valid keeps its
//   payload stable until that edge; ready may depend on state but never on
//   the same-cycle valid.
module uart_apb_master #(
  parameter int APB_ADDR_WIDTH = 32,
  parameter int APB_DATA_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                          apb_clk_in,
  input  logic                          apb_rstn_in,
  input  logic                          cmd_valid_in,
  output logic                          cmd_ready_out,
  input  logic [APB_ADDR_WIDTH-1:0]     cmd_addr_in,
  input  logic                          cmd_write_in,
  input  logic [APB_DATA_WIDTH-1:0]     cmd_wdata_in,
  input  logic [APB_DATA_WIDTH/8-1:0]   cmd_strb_in,
  output logic                          rsp_valid_out,
  input  logic                          rsp_ready_in,
  output logic [APB_DATA_WIDTH-1:0]     rsp_rdata_out,
  output logic                          rsp_err_out,
  output logic                          rsp_timeout_out,
  output logic [APB_ADDR_WIDTH-1:0]     apb_addr_out,
  output logic [APB_DATA_WIDTH-1:0]     apb_wdata_out,
  output logic [APB_DATA_WIDTH/8-1:0]   apb_strb_out,
  output logic                          apb_write_out,
  output logic                          apb_psel_out,
  output logic                          apb_penable_out,
  input  logic [APB_DATA_WIDTH-1:0]     apb_rdata_in,
  input  logic                          apb_ready_in,
  input  logic                          apb_slverr_in,
  output logic [1:0]                    dbg_state_out
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("uart_apb_master: TIMEOUT_CYCLES must be in 1..255");
  end

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

  state_e                        state_q, state_d;
  logic                          cmd_ready_d;
  logic                          rsp_valid_d;
  logic [APB_DATA_WIDTH-1:0]     rsp_rdata_d;
  logic                          rsp_err_d;
  logic [APB_ADDR_WIDTH-1:0]     apb_addr_d;
  logic [APB_DATA_WIDTH-1:0]     apb_wdata_d;
  logic [APB_DATA_WIDTH/8-1:0]   apb_strb_d;
  logic                          apb_write_d;
  logic                          apb_psel_d;
  logic                          apb_penable_d;

`ifdef APB_MASTER_TIMEOUT_EN
  logic [7:0] acc_cnt_q, acc_cnt_d;
  logic       rsp_timeout_d;
  logic       timeout_hit;

  // acc_cnt_q counts completed not-ready ACCESS cycles, so the current cycle
  // is number acc_cnt_q+1; the limit is reached on cycle TIMEOUT_CYCLES.
  assign timeout_hit = ({1'b0, acc_cnt_q} + 9'd1) >= 9'(TIMEOUT_CYCLES);
`else
  assign rsp_timeout_out = 1'b0;
`endif

  assign dbg_state_out = state_q;

  always_comb begin
    state_d       = state_q;
    cmd_ready_d   = cmd_ready_out;
    rsp_valid_d   = rsp_valid_out;
    rsp_rdata_d   = rsp_rdata_out;
    rsp_err_d     = rsp_err_out;
    apb_addr_d    = apb_addr_out;
    apb_wdata_d   = apb_wdata_out;
    apb_strb_d    = apb_strb_out;
    apb_write_d   = apb_write_out;
    apb_psel_d    = apb_psel_out;
    apb_penable_d = apb_penable_out;
`ifdef APB_MASTER_TIMEOUT_EN
    acc_cnt_d     = acc_cnt_q;
    rsp_timeout_d = rsp_timeout_out;
`endif

    unique case (state_q)
      ST_IDLE: begin
        // cmd_ready_out is low for the first cycle after reset release, so
        // nothing can be accepted until the flop has risen.
        if (cmd_valid_in && cmd_ready_out) begin
          apb_addr_d    = cmd_addr_in;
          apb_write_d   = cmd_write_in;
          apb_wdata_d   = cmd_write_in ? cmd_wdata_in : '0;
          apb_strb_d    = cmd_write_in ? cmd_strb_in  : '0;
          apb_psel_d    = 1'b1;
          apb_penable_d = 1'b0;
          cmd_ready_d   = 1'b0;
          state_d       = ST_SETUP;
        end else begin
          cmd_ready_d   = 1'b1;
        end
      end

      ST_SETUP: begin
        apb_penable_d = 1'b1;
        state_d       = ST_ACCESS;
`ifdef APB_MASTER_TIMEOUT_EN
        acc_cnt_d     = '0;
`endif
      end

      ST_ACCESS: begin
        // A ready on the limit cycle is a normal completion: it is tested first.
        if (apb_ready_in) begin
          rsp_rdata_d   = apb_write_out ? '0 : apb_rdata_in;
          rsp_err_d     = apb_slverr_in;
          rsp_valid_d   = 1'b1;
          apb_psel_d    = 1'b0;
          apb_penable_d = 1'b0;
          state_d       = ST_RESP;
`ifdef APB_MASTER_TIMEOUT_EN
          rsp_timeout_d = 1'b0;
`endif
        end
`ifdef APB_MASTER_TIMEOUT_EN
        else if (timeout_hit) begin
          rsp_rdata_d   = '0;
          rsp_err_d     = 1'b1;
          rsp_timeout_d = 1'b1;
          rsp_valid_d   = 1'b1;
          apb_psel_d    = 1'b0;
          apb_penable_d = 1'b0;
          state_d       = ST_RESP;
        end else begin
          acc_cnt_d     = acc_cnt_q + 8'd1;
        end
`endif
      end

      ST_RESP: begin
        if (rsp_ready_in) begin
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
          state_d     = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge apb_clk_in or negedge apb_rstn_in) begin
    if (!apb_rstn_in) begin
      state_q         <= ST_IDLE;
      cmd_ready_out   <= 1'b0;
      rsp_valid_out   <= 1'b0;
      rsp_rdata_out   <= '0;
      rsp_err_out     <= 1'b0;
      apb_addr_out    <= '0;
      apb_wdata_out   <= '0;
      apb_strb_out    <= '0;
      apb_write_out   <= 1'b0;
      apb_psel_out    <= 1'b0;
      apb_penable_out <= 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
      acc_cnt_q       <= '0;
      rsp_timeout_out <= 1'b0;
`endif
    end else begin
      state_q         <= state_d;
      cmd_ready_out   <= cmd_ready_d;
      rsp_valid_out   <= rsp_valid_d;
      rsp_rdata_out   <= rsp_rdata_d;
      rsp_err_out     <= rsp_err_d;
      apb_addr_out    <= apb_addr_d;
      apb_wdata_out   <= apb_wdata_d;
      apb_strb_out    <= apb_strb_d;
      apb_write_out   <= apb_write_d;
      apb_psel_out    <= apb_psel_d;
      apb_penable_out <= apb_penable_d;
`ifdef APB_MASTER_TIMEOUT_EN
      acc_cnt_q       <= acc_cnt_d;
      rsp_timeout_out <= rsp_timeout_d;
`endif
    end
  end

endmodule
